// File: rtl/key_cfg_scheduler.sv
// Round-robin key request scheduler: turns debounced key pulses into mode/amplitude
// config words delivered over a valid/ready port, followed by a settle gap.
module key_cfg_scheduler #(
    parameter int MODE_W     = 3,
    parameter int MODE_MAX   = 5,
    parameter int AMP_W      = 8,
    parameter int AMP_INIT   = 128,
    parameter int AMP_STEP   = 16,
    parameter int GAP_CYCLES = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [3:0]        key_flag,
    output logic              cfg_valid,
    input  logic              cfg_ready,
    output logic [MODE_W-1:0] cfg_mode,
    output logic [AMP_W-1:0]  cfg_amp,
    output logic [1:0]        cfg_src,
    output logic              cfg_sat,
    output logic              drop_err,
    output logic              busy
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]  GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
    localparam logic [MODE_W-1:0] MODE_TOP = MODE_W'(MODE_MAX);
    localparam logic [AMP_W-1:0]  AMP_RST  = AMP_W'(AMP_INIT);
    localparam logic [AMP_W:0]    AMP_INC  = (AMP_W + 1)'(AMP_STEP);
    localparam logic [AMP_W-1:0]  AMP_DEC  = AMP_W'(AMP_STEP);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t            state, state_nxt;
    logic [3:0]        pend, pend_nxt;
    logic [3:0]        clr;
    logic [1:0]        rr_ptr, rr_nxt;
    logic [MODE_W-1:0] mode, mode_nxt, mode_new;
    logic [AMP_W-1:0]  amp, amp_nxt, amp_new;
    logic [AMP_W:0]    amp_sum;
    logic [1:0]        src, src_nxt;
    logic              valid, valid_nxt;
    logic              sat, sat_nxt;
    logic              drop, drop_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_nxt;
    logic [1:0]        win, idx;
    logic              found;
    logic              changed;

    // Round-robin search: first pending bit at or after rr_ptr, wrapping.
    always_comb begin
        win   = rr_ptr;
        idx   = rr_ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!found && pend[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // Candidate shadow value if the winning key were served now.
    always_comb begin
        amp_sum  = {1'b0, amp} + AMP_INC;
        mode_new = mode;
        amp_new  = amp;
        case (win)
            2'd0:    mode_new = (mode == MODE_TOP) ? '0 : mode + MODE_W'(1);
            2'd1:    mode_new = (mode == '0) ? MODE_TOP : mode - MODE_W'(1);
            2'd2:    amp_new  = amp_sum[AMP_W] ? '1 : amp_sum[AMP_W-1:0];
            default: amp_new  = (amp < AMP_DEC) ? '0 : amp - AMP_DEC;
        endcase
        changed = (mode_new != mode) || (amp_new != amp);
    end

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        mode_nxt  = mode;
        amp_nxt   = amp;
        src_nxt   = src;
        valid_nxt = valid;
        sat_nxt   = 1'b0;
        gap_nxt   = gap_cnt;
        clr       = '0;

        case (state)
            IDLE: begin
                if (pend != '0) begin
                    clr[win] = 1'b1;
                    rr_nxt   = win + 2'd1;
                    if (changed) begin
                        mode_nxt  = mode_new;
                        amp_nxt   = amp_new;
                        src_nxt   = win;
                        valid_nxt = 1'b1;
                        state_nxt = SEND;
                    end else begin
                        sat_nxt   = 1'b1;
                        gap_nxt   = GAP_LOAD;
                        state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
                    end
                end
            end
            SEND: begin
                if (cfg_ready) begin
                    valid_nxt = 1'b0;
                    gap_nxt   = GAP_LOAD;
                    state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt - GAP_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A fresh pulse on a bit being granted this cycle re-arms it without a drop.
        pend_nxt = key_flag | (pend & ~clr);
        drop_nxt = |(key_flag & pend & ~clr);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= IDLE;
            pend    <= '0;
            rr_ptr  <= '0;
            mode    <= '0;
            amp     <= AMP_RST;
            src     <= '0;
            valid   <= 1'b0;
            sat     <= 1'b0;
            drop    <= 1'b0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            pend    <= pend_nxt;
            rr_ptr  <= rr_nxt;
            mode    <= mode_nxt;
            amp     <= amp_nxt;
            src     <= src_nxt;
            valid   <= valid_nxt;
            sat     <= sat_nxt;
            drop    <= drop_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    assign cfg_valid = valid;
    assign cfg_mode  = mode;
    assign cfg_amp   = amp;
    assign cfg_src   = src;
    assign cfg_sat   = sat;
    assign drop_err  = drop;
    assign busy      = (state != IDLE) || (pend != '0);

endmodule

// File: tb/tb_key_cfg_scheduler.sv
// Bench for key_cfg_scheduler: directed scenarios plus random key bursts checked
// against a transaction-level model of the served mode/amplitude sequence.
module tb_key_cfg_scheduler;

    localparam int MODE_W   = 3;
    localparam int MODE_MAX = 5;
    localparam int AMP_W    = 8;
    localparam int AMP_INIT = 128;
    localparam int AMP_STEP = 16;
    localparam int GAP_N    = 4;
    localparam int AMP_TOP  = (1 << AMP_W) - 1;

    logic              sys_clk;
    logic              sys_rst_n;
    logic [3:0]        key_flag;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [MODE_W-1:0] cfg_mode;
    logic [AMP_W-1:0]  cfg_amp;
    logic [1:0]        cfg_src;
    logic              cfg_sat;
    logic              drop_err;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int m_mode, m_amp, m_rr;

    key_cfg_scheduler #(
        .MODE_W(MODE_W), .MODE_MAX(MODE_MAX), .AMP_W(AMP_W),
        .AMP_INIT(AMP_INIT), .AMP_STEP(AMP_STEP), .GAP_CYCLES(GAP_N)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_flag(key_flag),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
        .cfg_amp(cfg_amp), .cfg_src(cfg_src), .cfg_sat(cfg_sat),
        .drop_err(drop_err), .busy(busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge sys_clk);
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0;
        m_amp  = AMP_INIT;
        m_rr   = 0;
    endfunction

    // Serve key k on the model; returns whether the shadow value changed.
    function automatic bit model_apply(int k);
        int nm, na;
        nm = m_mode;
        na = m_amp;
        case (k)
            0:       nm = (m_mode == MODE_MAX) ? 0 : m_mode + 1;
            1:       nm = (m_mode == 0) ? MODE_MAX : m_mode - 1;
            2:       na = (m_amp + AMP_STEP > AMP_TOP) ? AMP_TOP : m_amp + AMP_STEP;
            default: na = (m_amp - AMP_STEP < 0) ? 0 : m_amp - AMP_STEP;
        endcase
        model_apply = (nm != m_mode) || (na != m_amp);
        m_mode = nm;
        m_amp  = na;
    endfunction

    function automatic int model_pick(logic [3:0] left);
        for (int j = 0; j < 4; j++) begin
            if (left[(m_rr + j) % 4]) return (m_rr + j) % 4;
        end
        return 0;
    endfunction

    task automatic do_reset();
        sys_rst_n = 1'b0;
        key_flag  = '0;
        cfg_ready = 1'b0;
        tick();
        tick();
        check_output("rst_valid", cfg_valid, 0);
        check_output("rst_mode", cfg_mode, 0);
        check_output("rst_amp", cfg_amp, AMP_INIT);
        check_output("rst_src", cfg_src, 0);
        check_output("rst_sat", cfg_sat, 0);
        check_output("rst_drop", drop_err, 0);
        check_output("rst_busy", busy, 0);
        sys_rst_n = 1'b1;
        model_reset();
        tick();
    endtask

    // Pulse a key mask from idle and follow every resulting grant to completion.
    task automatic apply_stimulus(input logic [3:0] mask, input int stall);
        logic [3:0] left;
        int k, waits, prev_gap, last_rise;
        bit got, changed, first, last_valid;
        left       = mask;
        first      = 1'b1;
        last_valid = 1'b0;
        prev_gap   = 0;
        last_rise  = 0;
        cfg_ready  = (stall == 0);
        key_flag   = mask;
        tick();
        key_flag = '0;
        while (left != '0) begin
            k        = model_pick(left);
            left[k]  = 1'b0;
            m_rr     = (k + 1) % 4;
            changed  = model_apply(k);
            cfg_ready = (stall == 0);
            waits = 0;
            got   = 1'b0;
            while (!got && waits < 40) begin
                tick();
                waits++;
                got = cfg_valid || cfg_sat;
            end
            if (!got) begin
                check_output("event_timeout", 0, 1);
                return;
            end
            if (first) check_output("grant_latency", waits, 1);
            else       check_output("grant_spacing", cyc - last_rise, prev_gap);
            last_rise = cyc;
            first     = 1'b0;
            if (changed) begin
                check_output("xfer_valid", cfg_valid, 1);
                check_output("xfer_sat", cfg_sat, 0);
                check_output("xfer_mode", cfg_mode, m_mode);
                check_output("xfer_amp", cfg_amp, m_amp);
                check_output("xfer_src", cfg_src, k);
                for (int i = 0; i < stall; i++) begin
                    tick();
                    check_output("hold_valid", cfg_valid, 1);
                    check_output("hold_mode", cfg_mode, m_mode);
                    check_output("hold_amp", cfg_amp, m_amp);
                    check_output("hold_src", cfg_src, k);
                end
                cfg_ready = 1'b1;
                tick();
                check_output("xfer_done", cfg_valid, 0);
                prev_gap   = 2 + GAP_N + stall;
                last_valid = 1'b1;
            end else begin
                check_output("sat_pulse", cfg_sat, 1);
                check_output("sat_novalid", cfg_valid, 0);
                check_output("sat_mode", cfg_mode, m_mode);
                check_output("sat_amp", cfg_amp, m_amp);
                tick();
                check_output("sat_oneshot", cfg_sat, 0);
                prev_gap   = 1 + GAP_N;
                last_valid = 1'b0;
            end
        end
        for (int i = 0; i < (last_valid ? GAP_N - 1 : GAP_N - 2); i++) tick();
        check_output("gap_busy", busy, 1);
        tick();
        check_output("idle_busy", busy, 0);
    endtask

    initial begin
        int waits, rises;
        logic [3:0] mask;
        sys_rst_n = 1'b0;
        key_flag  = '0;
        cfg_ready = 1'b0;
        model_reset();

        $display("[TB] single mode-next press");
        do_reset();
        apply_stimulus(4'b0001, 0);

        $display("[TB] all four keys at once");
        do_reset();
        apply_stimulus(4'b1111, 0);

        $display("[TB] ten-cycle backpressure");
        do_reset();
        apply_stimulus(4'b0001, 10);

        $display("[TB] mode wrap forward and back");
        do_reset();
        for (int i = 0; i < 6; i++) apply_stimulus(4'b0001, 0);
        apply_stimulus(4'b0010, 0);

        $display("[TB] amplitude saturation both ends");
        do_reset();
        for (int i = 0; i < 9; i++) apply_stimulus(4'b0100, 0);
        for (int i = 0; i < 17; i++) apply_stimulus(4'b1000, 0);

        $display("[TB] drop detection and reset mid-send");
        do_reset();
        key_flag = 4'b0100;
        tick();
        key_flag = '0;
        tick();
        void'(model_apply(2));
        check_output("drop_first_valid", cfg_valid, 1);
        check_output("drop_first_amp", cfg_amp, m_amp);
        key_flag = 4'b0100;
        tick();
        key_flag = '0;
        check_output("drop_none", drop_err, 0);
        key_flag = 4'b0100;
        tick();
        key_flag = '0;
        check_output("drop_pulse", drop_err, 1);
        check_output("drop_hold_amp", cfg_amp, m_amp);
        tick();
        check_output("drop_oneshot", drop_err, 0);
        cfg_ready = 1'b1;
        tick();
        check_output("drop_first_done", cfg_valid, 0);
        cfg_ready = 1'b0;
        void'(model_apply(2));
        waits = 0;
        while (!cfg_valid && waits < 40) begin
            tick();
            waits++;
        end
        check_output("regrant_wait", waits, GAP_N + 1);
        check_output("regrant_amp", cfg_amp, m_amp);
        check_output("regrant_src", cfg_src, 2);
        sys_rst_n = 1'b0;
        #1;
        check_output("midrst_valid", cfg_valid, 0);
        check_output("midrst_amp", cfg_amp, AMP_INIT);
        check_output("midrst_busy", busy, 0);
        tick();
        sys_rst_n = 1'b1;
        model_reset();
        cfg_ready = 1'b1;
        rises = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cfg_valid) rises++;
        end
        check_output("post_rst_quiet", rises, 0);

        $display("[TB] random bursts");
        do_reset();
        for (int it = 0; it < 60; it++) begin
            mask = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 2) == 0) mask = ($urandom_range(0, 1) != 0) ? 4'b0100 : 4'b1000;
            apply_stimulus(mask, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
